// File: rtl/aes_sbox_pipe.sv
// AES forward/inverse S-box over LANES bytes, pipelined to STAGES cycles, using a composite-field GF((2^4)^2) inverter.
// Defining SBOX_PERF_EN adds the saturating delivered-transfer counter output Cnt_xfer.
module aes_sbox_pipe #(
  parameter int LANES  = 4,
  parameter int STAGES = 2
) (
  input  logic               CLK,
  input  logic               RSTn,
  input  logic               CLR,
  input  logic [8*LANES-1:0] Din,
  input  logic               EncDec,
  input  logic               Drdy,
  output logic               Irdy,
  output logic [8*LANES-1:0] Dout,
  output logic               Dvld,
  input  logic               Ordy
`ifdef SBOX_PERF_EN
  ,
  output logic [15:0]        Cnt_xfer
`endif
);

  function automatic logic [1:0] gf2_mul(input logic [1:0] a, input logic [1:0] b);
    return {(a[1] & b[1]) ^ (a[0] & b[1]) ^ (a[1] & b[0]), (a[1] & b[1]) ^ (a[0] & b[0])};
  endfunction

  function automatic logic [1:0] gf2_mul_phi(input logic [1:0] a);
    return {a[1] ^ a[0], a[1]};
  endfunction

  function automatic logic [3:0] gf4_mul(input logic [3:0] a, input logic [3:0] b);
    logic [1:0] hh;
    logic [1:0] ll;
    logic [1:0] mm;
    hh = gf2_mul(a[3:2], b[3:2]);
    ll = gf2_mul(a[1:0], b[1:0]);
    mm = gf2_mul(a[3:2] ^ a[1:0], b[3:2] ^ b[1:0]);
    return {mm ^ ll, gf2_mul_phi(hh) ^ ll};
  endfunction

  function automatic logic [3:0] gf4_sq(input logic [3:0] a);
    return {a[3], a[3] ^ a[2], a[2] ^ a[1], a[3] ^ a[1] ^ a[0]};
  endfunction

  function automatic logic [3:0] gf4_mul_lambda(input logic [3:0] a);
    return {a[2] ^ a[0], a[3] ^ a[2] ^ a[1] ^ a[0], a[3], a[2]};
  endfunction

  function automatic logic [3:0] gf4_inv(input logic [3:0] x);
    logic [3:0] q;
    q[3] = x[3] ^ (x[3] & x[2] & x[1]) ^ (x[3] & x[0]) ^ x[2];
    q[2] = (x[3] & x[2] & x[1]) ^ (x[3] & x[2] & x[0]) ^ (x[3] & x[0]) ^ x[2] ^ (x[2] & x[1]);
    q[1] = x[3] ^ (x[3] & x[2] & x[1]) ^ (x[3] & x[1] & x[0]) ^ x[2] ^ (x[2] & x[0]) ^ x[1];
    q[0] = (x[3] & x[2] & x[1]) ^ (x[3] & x[2] & x[0]) ^ (x[3] & x[1]) ^ (x[3] & x[1] & x[0])
         ^ (x[3] & x[0]) ^ x[2] ^ (x[2] & x[1]) ^ (x[2] & x[1] & x[0]) ^ x[1] ^ x[0];
    return q;
  endfunction

  // Isomorphism from the polynomial basis mod 0x11B into the composite field.
  function automatic logic [7:0] iso_map(input logic [7:0] x);
    logic [7:0] q;
    q[7] = x[7] ^ x[5];
    q[6] = x[7] ^ x[6] ^ x[4] ^ x[3] ^ x[2] ^ x[1];
    q[5] = x[7] ^ x[5] ^ x[3] ^ x[2];
    q[4] = x[7] ^ x[5] ^ x[3] ^ x[2] ^ x[1];
    q[3] = x[7] ^ x[6] ^ x[2] ^ x[1];
    q[2] = x[7] ^ x[4] ^ x[3] ^ x[2] ^ x[1];
    q[1] = x[6] ^ x[4] ^ x[1];
    q[0] = x[6] ^ x[1] ^ x[0];
    return q;
  endfunction

  function automatic logic [7:0] iso_inv(input logic [7:0] x);
    logic [7:0] q;
    q[7] = x[7] ^ x[6] ^ x[5] ^ x[1];
    q[6] = x[6] ^ x[2];
    q[5] = x[6] ^ x[5] ^ x[1];
    q[4] = x[6] ^ x[5] ^ x[4] ^ x[2] ^ x[1];
    q[3] = x[5] ^ x[4] ^ x[3] ^ x[2] ^ x[1];
    q[2] = x[7] ^ x[4] ^ x[3] ^ x[2] ^ x[1];
    q[1] = x[5] ^ x[4];
    q[0] = x[6] ^ x[5] ^ x[4] ^ x[2] ^ x[0];
    return q;
  endfunction

  function automatic logic [7:0] fwd_affine(input logic [7:0] a);
    return a ^ {a[6:0], a[7]} ^ {a[5:0], a[7:6]} ^ {a[4:0], a[7:5]} ^ {a[3:0], a[7:4]};
  endfunction

  function automatic logic [7:0] inv_affine(input logic [7:0] a);
    return {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]};
  endfunction

  // p = {ah, al, d}: d is the GF(2^4) value that must be inverted, ah/al are reused afterwards.
  function automatic logic [11:0] p_calc(input logic [7:0] iso);
    logic [3:0] ah;
    logic [3:0] al;
    ah = iso[7:4];
    al = iso[3:0];
    return {ah, al, gf4_mul_lambda(gf4_sq(ah)) ^ gf4_mul(ah ^ al, al)};
  endfunction

  function automatic logic [7:0] back_calc(input logic [11:0] p, input logic mode);
    logic [3:0] d_inv;
    logic [7:0] inv8;
    d_inv = gf4_inv(p[3:0]);
    inv8  = iso_inv({gf4_mul(p[11:8], d_inv), gf4_mul(p[11:8] ^ p[7:4], d_inv)});
    return mode ? inv8 : (fwd_affine(inv8) ^ 8'h63);
  endfunction

  logic                dvld_r;
  logic [8*LANES-1:0]  dout_r;
  logic                adv_s;
  logic                acc_s;
  logic [8*LANES-1:0]  iso_s;
  logic [8*LANES-1:0]  iso_q_s;
  logic                iso_v_s;
  logic                iso_m_s;
  logic [12*LANES-1:0] p_s;
  logic [12*LANES-1:0] p_q_s;
  logic                p_v_s;
  logic                p_m_s;
  logic [8*LANES-1:0]  res_s;

  // One stall signal freezes every stage when the output is held.
  assign adv_s = !(dvld_r && !Ordy);
  assign Irdy  = Ordy || !dvld_r;
  assign acc_s = Drdy && Irdy;
  assign Dvld  = dvld_r;
  assign Dout  = dout_r;

  // Front end: optional inverse affine, then map every lane into the composite field.
  always_comb begin
    iso_s = '0;
    for (int k = 0; k < LANES; k++) begin
      iso_s[8*k +: 8] = iso_map(EncDec ? (inv_affine(Din[8*k +: 8]) ^ 8'h05) : Din[8*k +: 8]);
    end
  end

  if (STAGES >= 3) begin : g_iso_reg
    logic [8*LANES-1:0] iso_r;
    logic               iso_v_r;
    logic               iso_m_r;
    // Register after the isomorphism mapping.
    always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
        iso_v_r <= 1'b0;
        iso_m_r <= 1'b0;
        iso_r   <= '0;
      end else if (CLR) begin
        iso_v_r <= 1'b0;
      end else if (adv_s) begin
        iso_v_r <= acc_s;
        iso_m_r <= EncDec;
        iso_r   <= iso_s;
      end
    end
    assign iso_q_s = iso_r;
    assign iso_v_s = iso_v_r;
    assign iso_m_s = iso_m_r;
  end else begin : g_iso_pass
    assign iso_q_s = iso_s;
    assign iso_v_s = acc_s;
    assign iso_m_s = EncDec;
  end

  // Build the GF(2^4) inversion operand for every lane.
  always_comb begin
    p_s = '0;
    for (int k = 0; k < LANES; k++) begin
      p_s[12*k +: 12] = p_calc(iso_q_s[8*k +: 8]);
    end
  end

  if (STAGES >= 2) begin : g_p_reg
    logic [12*LANES-1:0] p_r;
    logic                p_v_r;
    logic                p_m_r;
    // Register on the GF(2^4) inversion input.
    always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
        p_v_r <= 1'b0;
        p_m_r <= 1'b0;
        p_r   <= '0;
      end else if (CLR) begin
        p_v_r <= 1'b0;
      end else if (adv_s) begin
        p_v_r <= iso_v_s;
        p_m_r <= iso_m_s;
        p_r   <= p_s;
      end
    end
    assign p_q_s = p_r;
    assign p_v_s = p_v_r;
    assign p_m_s = p_m_r;
  end else begin : g_p_pass
    assign p_q_s = p_s;
    assign p_v_s = iso_v_s;
    assign p_m_s = iso_m_s;
  end

  // Back end: finish the inversion, map back, apply the forward affine when encrypting.
  always_comb begin
    res_s = '0;
    for (int k = 0; k < LANES; k++) begin
      res_s[8*k +: 8] = back_calc(p_q_s[12*k +: 12], p_m_s);
    end
  end

  // Output register; data only loads with a valid transfer so Dout never shows bubble garbage.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      dvld_r <= 1'b0;
      dout_r <= '0;
    end else if (CLR) begin
      dvld_r <= 1'b0;
    end else if (adv_s) begin
      dvld_r <= p_v_s;
      if (p_v_s) begin
        dout_r <= res_s;
      end
    end
  end

`ifdef SBOX_PERF_EN
  logic [15:0] cnt_r;
  // Saturating count of delivered transfers.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      cnt_r <= 16'h0000;
    end else if (CLR) begin
      cnt_r <= 16'h0000;
    end else if (dvld_r && Ordy && (cnt_r != 16'hFFFF)) begin
      cnt_r <= cnt_r + 16'h0001;
    end
  end
  assign Cnt_xfer = cnt_r;
`endif

endmodule

// File: tb/tb_aes_sbox_pipe.sv
// Scoreboard bench for aes_sbox_pipe: three instances (STAGES=1,2,3) share stimulus, each with its own monitor.
// Counter checks are compiled in when SBOX_PERF_EN is defined.
module tb_aes_sbox_pipe;
  localparam int LANES = 4;

  logic        CLK = 1'b0;
  logic        RSTn;
  logic        CLR;
  logic [31:0] Din;
  logic        EncDec;
  logic        Drdy;
  logic        Ordy;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  logic [7:0] sbox [256];
  logic [7:0] isbox [256];

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input int dut, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s stages=%0d: got %h, expected %h", name, dut + 1, act, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1B) : (aa << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] a, input int n);
    return 8'((a << n) | (a >> (8 - n)));
  endfunction

  task automatic build_tables();
    logic [7:0] inv;
    logic [7:0] x;
    for (int v = 0; v < 256; v++) begin
      x = 8'(v);
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
      end
      sbox[v] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
    for (int v = 0; v < 256; v++) isbox[sbox[v]] = 8'(v);
  endtask

  function automatic logic [31:0] model(input logic [31:0] d, input logic m);
    logic [31:0] r;
    for (int k = 0; k < LANES; k++) r[8*k +: 8] = m ? isbox[d[8*k +: 8]] : sbox[d[8*k +: 8]];
    return r;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic [31:0] dout_w;
    logic        irdy_w;
    logic        dvld_w;
`ifdef SBOX_PERF_EN
    logic [15:0] cnt_w;
`endif
    aes_sbox_pipe #(.LANES(LANES), .STAGES(g + 1)) u_dut (
      .CLK(CLK), .RSTn(RSTn), .CLR(CLR), .Din(Din), .EncDec(EncDec), .Drdy(Drdy),
      .Irdy(irdy_w), .Dout(dout_w), .Dvld(dvld_w), .Ordy(Ordy)
`ifdef SBOX_PERF_EN
      , .Cnt_xfer(cnt_w)
`endif
    );

    logic [31:0] exp_q [$];
    int          acc_q [$];
    int          last_low = -1;
    int          pend = 0;
    logic        hold_p = 1'b0;
    logic [31:0] hold_d = 32'h0;

    always @(negedge CLK) begin
      logic [31:0] e;
      int          a;
      int          lat;
      if (!RSTn) begin
        exp_q.delete();
        acc_q.delete();
        hold_p = 1'b0;
      end else begin
        if (!Ordy) last_low = cyc + 1;
        check("irdy_rule", g, 32'(irdy_w), 32'(Ordy || !dvld_w));
        if (hold_p) begin
          check("hold_vld", g, 32'(dvld_w), 32'd1);
          check("hold_dout", g, dout_w, hold_d);
        end
        if (dvld_w && Ordy) begin
          check("sb_expected", g, 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            a = acc_q.pop_front();
            check("data", g, dout_w, e);
            lat = cyc + 1 - a;
            if (last_low < a) check("latency", g, 32'(lat), 32'(g + 1));
            else check("latency_min", g, 32'(lat >= g + 1), 32'd1);
          end
        end
        if (Drdy && irdy_w && !CLR) begin
          exp_q.push_back(model(Din, EncDec));
          acc_q.push_back(cyc + 1);
        end
        if (CLR) begin
          exp_q.delete();
          acc_q.delete();
        end
        hold_p = dvld_w && !Ordy && !CLR;
        hold_d = dout_w;
      end
      pend = exp_q.size();
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_idle(input string name, input logic with_dout);
    check(name, 0, 32'(g_dut[0].dvld_w), 32'd0);
    check(name, 1, 32'(g_dut[1].dvld_w), 32'd0);
    check(name, 2, 32'(g_dut[2].dvld_w), 32'd0);
    if (with_dout) begin
      check({name, "_dout"}, 0, g_dut[0].dout_w, 32'h0);
      check({name, "_dout"}, 1, g_dut[1].dout_w, 32'h0);
      check({name, "_dout"}, 2, g_dut[2].dout_w, 32'h0);
      check({name, "_irdy"}, 0, 32'(g_dut[0].irdy_w), 32'd1);
      check({name, "_irdy"}, 1, 32'(g_dut[1].irdy_w), 32'd1);
      check({name, "_irdy"}, 2, 32'(g_dut[2].irdy_w), 32'd1);
    end
  endtask

`ifdef SBOX_PERF_EN
  task automatic check_cnt(input string name, input logic [15:0] exp);
    check(name, 0, 32'(g_dut[0].cnt_w), 32'(exp));
    check(name, 1, 32'(g_dut[1].cnt_w), 32'(exp));
    check(name, 2, 32'(g_dut[2].cnt_w), 32'(exp));
  endtask
`endif

  initial begin
    int n;
    RSTn = 1'b0; CLR = 1'b0; Din = 32'h0; EncDec = 1'b0; Drdy = 1'b0; Ordy = 1'b1;
    build_tables();
    repeat (2) step();
    check_idle("reset", 1'b1);

    // Directed forward transfer, accepted on the first edge after reset release.
    RSTn = 1'b1; Din = 32'h0001_53FF; EncDec = 1'b0; Drdy = 1'b1;
    step();
    Drdy = 1'b0;
    step();
    check("fwd_vld", 1, 32'(g_dut[1].dvld_w), 32'd1);
    check("fwd_dout", 1, g_dut[1].dout_w, 32'h637C_ED16);
    step();
    check("fwd_one_cycle", 1, 32'(g_dut[1].dvld_w), 32'd0);

    // Directed inverse transfer, then alternating modes.
    Din = 32'h637C_ED16; EncDec = 1'b1; Drdy = 1'b1;
    step();
    Drdy = 1'b0;
    step();
    check("inv_vld", 1, 32'(g_dut[1].dvld_w), 32'd1);
    check("inv_dout", 1, g_dut[1].dout_w, 32'h0001_53FF);
    for (int i = 0; i < 8; i++) begin
      Din = $urandom; EncDec = i[0]; Drdy = 1'b1;
      step();
    end
    Drdy = 1'b0;
    repeat (5) step();

    // Stream with a three-cycle downstream stall.
    n = 0;
    Din = $urandom; EncDec = 1'($urandom);
    for (int c = 0; c < 20 && n < 6; c++) begin
      Ordy = !(c >= 2 && c < 5); Drdy = 1'b1;
      #1;
      if (!Ordy) check("stall_irdy", 1, 32'(g_dut[1].irdy_w), 32'd0);
      if (g_dut[1].irdy_w) n++;
      step();
      if (g_dut[1].irdy_w || Ordy) begin
        Din = $urandom; EncDec = 1'($urandom);
      end
    end
    check("stream_count", 1, 32'(n), 32'd6);
    Drdy = 1'b0; Ordy = 1'b1;
    repeat (6) step();

    // Flush with transfers in flight and a simultaneous accept request.
    Ordy = 1'b0; Drdy = 1'b1; Din = $urandom;
    step();
    Din = $urandom;
    step();
    CLR = 1'b1; Din = $urandom;
    step();
    CLR = 1'b0; Drdy = 1'b0;
    check_idle("clr_vld", 1'b0);
    Ordy = 1'b1;
    repeat (4) begin
      step();
      check_idle("clr_none", 1'b0);
    end

    // Every byte value on every lane, both modes, no stalls.
    for (int v = 0; v < 256; v++) begin
      for (int m = 0; m < 2; m++) begin
        for (int k = 0; k < LANES; k++) Din[8*k +: 8] = 8'(v + 64 * k);
        EncDec = m[0]; Drdy = 1'b1;
        step();
      end
    end
    Drdy = 1'b0;
    repeat (5) step();

    // Randomized traffic with random back-pressure and occasional flushes.
    for (int i = 0; i < 300; i++) begin
      Drdy = ($urandom_range(0, 3) != 0);
      Ordy = ($urandom_range(0, 3) != 0);
      EncDec = 1'($urandom);
      Din = $urandom;
      CLR = ($urandom_range(0, 39) == 0);
      step();
    end
    CLR = 1'b0; Drdy = 1'b0; Ordy = 1'b1;
    repeat (6) step();

    // Counter: clear, five deliveries, then reset mid-stream.
    CLR = 1'b1;
    step();
    CLR = 1'b0;
`ifdef SBOX_PERF_EN
    check_cnt("cnt_clr", 16'd0);
`endif
    for (int i = 0; i < 5; i++) begin
      Din = $urandom; EncDec = 1'($urandom); Drdy = 1'b1;
      step();
    end
    Drdy = 1'b0;
    repeat (5) step();
`ifdef SBOX_PERF_EN
    check_cnt("cnt_five", 16'd5);
`endif
    Drdy = 1'b1;
    repeat (3) begin
      Din = $urandom;
      step();
    end
    RSTn = 1'b0;
    #1;
    check_idle("midrst", 1'b1);
`ifdef SBOX_PERF_EN
    check_cnt("cnt_rst", 16'd0);
`endif
    Drdy = 1'b0;
    repeat (2) step();
    RSTn = 1'b1; Drdy = 1'b1; Din = $urandom; EncDec = 1'b0;
    step();
    Drdy = 1'b0;
    repeat (6) step();

    check("drained", 0, 32'(g_dut[0].pend), 32'd0);
    check("drained", 1, 32'(g_dut[1].pend), 32'd0);
    check("drained", 2, 32'(g_dut[2].pend), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
